// File: rtl/w25q32jv_fastread_resp.sv
// SPI target emulating the W25Q32JV Fast Read (0x0B) transaction from an internal byte memory.
// Optional macro W25Q_READ03_EN also accepts Read Data (0x03), which has no dummy phase.
module w25q32jv_fastread_resp #(
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned DUMMY_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              rd_active,
    output logic [23:0]       last_addr
);

    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_AW;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYC - 1);
    localparam bit NO_DUMMY = (DUMMY_CYC == 0);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    state_t              state_q, state_nxt;
    logic [2:0]          sclk_pipe, csn_pipe;
    logic [1:0]          mosi_pipe;
    logic [ADDR_W-2:0]   shift_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          byte_q;
    logic [7:0]          mem [MEM_DEPTH];
`ifdef W25Q_READ03_EN
    logic                rd03_q;
`endif

    logic              sclk_rise_c, sclk_fall_c, csn_rise_c, csn_fall_c, mosi_s_c;
    logic [7:0]        cmd_c;
    logic [ADDR_W-1:0] addr_c, addr_inc_c;
    logic              cmd_ok_c, skip_dummy_c;

    // csn flops reset low so a select already asserted at reset release is not seen as a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe <= '0;
            csn_pipe  <= '0;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            csn_pipe  <= {csn_pipe[1:0], csn};
            mosi_pipe <= {mosi_pipe[0], mosi};
        end
    end

    always_comb begin
        sclk_rise_c = sclk_pipe[1] & ~sclk_pipe[2];
        sclk_fall_c = ~sclk_pipe[1] & sclk_pipe[2];
        csn_rise_c  = csn_pipe[1] & ~csn_pipe[2];
        csn_fall_c  = ~csn_pipe[1] & csn_pipe[2];
        mosi_s_c    = mosi_pipe[1];
        cmd_c       = {shift_q[6:0], mosi_s_c};
        addr_c      = {shift_q, mosi_s_c};
        addr_inc_c  = addr_q + ADDR_W'(1);
`ifdef W25Q_READ03_EN
        cmd_ok_c     = (cmd_c == 8'h0B) || (cmd_c == 8'h03);
        skip_dummy_c = NO_DUMMY || rd03_q;
`else
        cmd_ok_c     = (cmd_c == 8'h0B);
        skip_dummy_c = NO_DUMMY;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    // Deselect has priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_nxt = state_q;
        if (csn_rise_c) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (csn_fall_c) state_nxt = CMD;
                CMD:    if (sclk_rise_c && cnt_q == CMD_LAST)
                            state_nxt = cmd_ok_c ? ADDR : IGNORE;
                ADDR:   if (sclk_rise_c && cnt_q == ADDR_LAST)
                            state_nxt = skip_dummy_c ? DATA : DUMMY;
                DUMMY:  if (sclk_rise_c && cnt_q == DUMMY_LAST) state_nxt = DATA;
                default: state_nxt = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    // Datapath: shift-in, address latch, byte fetch and MSB-first shift-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            rd_active <= 1'b0;
            last_addr <= '0;
            addr_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bit_idx_q <= 3'd7;
            byte_q    <= '0;
`ifdef W25Q_READ03_EN
            rd03_q    <= 1'b0;
`endif
        end else begin
            rd_active <= (state_nxt == DATA);
            if (csn_rise_c) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: cnt_q <= '0;
                    CMD: if (sclk_rise_c) begin
                        shift_q <= {shift_q[ADDR_W-3:0], mosi_s_c};
                        if (cnt_q == CMD_LAST) begin
                            cnt_q <= '0;
`ifdef W25Q_READ03_EN
                            rd03_q <= (cmd_c == 8'h03);
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ADDR: if (sclk_rise_c) begin
                        shift_q <= {shift_q[ADDR_W-3:0], mosi_s_c};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q     <= '0;
                            addr_q    <= addr_c;
                            last_addr <= addr_c;
                            if (skip_dummy_c) begin
                                byte_q    <= mem[addr_c[MEM_AW-1:0]];
                                bit_idx_q <= 3'd7;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DUMMY: if (sclk_rise_c) begin
                        if (cnt_q == DUMMY_LAST) begin
                            cnt_q     <= '0;
                            byte_q    <= mem[addr_q[MEM_AW-1:0]];
                            bit_idx_q <= 3'd7;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DATA: if (sclk_fall_c) begin
                        miso    <= byte_q[bit_idx_q];
                        miso_oe <= 1'b1;
                        if (bit_idx_q == 3'd0) begin
                            addr_q    <= addr_inc_c;
                            byte_q    <= mem[addr_inc_c[MEM_AW-1:0]];
                            bit_idx_q <= 3'd7;
                        end else begin
                            bit_idx_q <= bit_idx_q - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
